// File: rtl/mul8_pkg.sv
// Shared definitions for the sequential 8x8 multiplier: FSM encoding,
// step count and the per-step partial-product alignment.
package mul8_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int NIB_W  = 4;
  localparam int NSTEPS = 4;

  localparam logic [1:0] LAST_STEP = 2'(NSTEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Left shift that aligns each nibble product: aL*bL, aH*bL, aL*bH, aH*bH.
  function automatic logic [3:0] step_shift(input logic [1:0] step);
    logic [3:0] sh;
    case (step)
      2'd0:    sh = 4'd0;
      2'd1:    sh = 4'd4;
      2'd2:    sh = 4'd4;
      2'd3:    sh = 4'd8;
      default: sh = 4'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/mul8_seq_ctrl_if.sv
// Operand/product handshake bundle between a requester/consumer and the
// sequential multiplier.
interface mul8_seq_ctrl_if;
  import mul8_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] p;
  logic              busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, busy
  );

endinterface

// File: rtl/mul8_seq_ctrl_arr_mul.sv
// Purely combinational 4x4 unsigned array multiplier (shift-and-add rows).
module arr_mul (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] prod
);

  // One row of the array per multiplier bit.
  always_comb begin
    prod = 8'd0;
    for (int i = 0; i < 4; i++) begin
      if (y[i]) begin
        prod = prod + ({4'd0, x} << i);
      end else begin
        prod = prod;
      end
    end
  end

endmodule

// File: rtl/mul8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier: one shared 4x4 array multiplier is
// stepped over the four nibble pairs and the aligned results accumulated.
module mul8_seq_ctrl
  import mul8_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  mul8_seq_ctrl_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        step;
  logic [OP_W-1:0]   op_a;
  logic [OP_W-1:0]   op_b;
  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] acc_nxt;
  logic [PROD_W-1:0] prod;
  logic [NIB_W-1:0]  nib_a;
  logic [NIB_W-1:0]  nib_b;
  logic [7:0]        part;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              in_ready_nxt;
  logic              out_valid_nxt;
  logic              busy_nxt;
  logic              xfer;

  assign xfer = bus.in_valid && in_ready_q;

  // Step bit 0 picks the multiplicand nibble, step bit 1 the multiplier nibble.
  assign nib_a = step[0] ? op_a[7:4] : op_a[3:0];
  assign nib_b = step[1] ? op_b[7:4] : op_b[3:0];

  arr_mul u_arr_mul (
    .x    (nib_a),
    .y    (nib_b),
    .prod (part)
  );

  assign acc_nxt = acc + ({8'd0, part} << step_shift(step));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (xfer) state_nxt = MUL;
        else      state_nxt = IDLE;
      end
      MUL: begin
        if (step == LAST_STEP) state_nxt = DONE;
        else                   state_nxt = MUL;
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
        else               state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the upcoming state so they register cleanly.
  always_comb begin
    in_ready_nxt  = 1'b0;
    out_valid_nxt = 1'b0;
    busy_nxt      = 1'b1;
    case (state_nxt)
      IDLE: begin
        in_ready_nxt = 1'b1;
        busy_nxt     = 1'b0;
      end
      MUL: begin
        busy_nxt = 1'b1;
      end
      DONE: begin
        out_valid_nxt = 1'b1;
      end
      default: begin
        in_ready_nxt = 1'b1;
        busy_nxt     = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_nxt;
      out_valid_q <= out_valid_nxt;
      busy_q      <= busy_nxt;
    end
  end

  // Operand capture, step counter and accumulator; prod only moves on the final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a <= 8'd0;
      op_b <= 8'd0;
      step <= 2'd0;
      acc  <= 16'd0;
      prod <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            op_a <= bus.a;
            op_b <= bus.b;
            step <= 2'd0;
            acc  <= 16'd0;
          end else begin
            op_a <= op_a;
          end
        end
        MUL: begin
          acc  <= acc_nxt;
          step <= step + 2'd1;
          if (step == LAST_STEP) begin
            prod <= acc_nxt;
          end else begin
            prod <= prod;
          end
        end
        default: begin
          acc <= acc;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.p         = prod;

endmodule

// File: doc/mul8_seq_ctrl.md
MUL8_SEQ_CTRL -- requirements
Module: mul8_seq_ctrl

Interface
REQ-001 Parameters: none; operand width fixed at 8, product width fixed at 16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  requester presents an operand pair.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  8  multiplicand, unsigned.
REQ-007 b  input  8  multiplier, unsigned.
REQ-008 out_valid  output  1  product is valid and held.
REQ-009 out_ready  input  1  consumer accepts the product.
REQ-010 p  output  16  unsigned product a*b.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The block SHALL compute the 8x8 product by sequencing one shared 4x4 combinational multiplier over exactly 4 steps.
REQ-013 FSM states SHALL be IDLE, MUL and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; a transfer occurs on an edge where in_valid and in_ready are both 1.
REQ-015 On a transfer: latch a and b, clear the accumulator, clear step counter, go to MUL.
REQ-016 The step counter SHALL be 2 bits; in MUL it increments each cycle, 0 to 3.
REQ-017 Step 0: aL*bL, shift 0; step 1: aH*bL, shift 4; step 2: aL*bH, shift 4; step 3: aH*bH, shift 8. Here aL and aH are a[3:0] and a[7:4] of the latched operands; bL and bH likewise.
REQ-018 Each MUL step SHALL add the zero-extended, shifted 8-bit partial product into a 16-bit accumulator; no overflow is possible (max 0xFE01).
REQ-019 After step 3 accumulates, the FSM SHALL go to DONE.
REQ-020 In DONE, out_valid SHALL be 1 and p SHALL equal the accumulator, held stable until out_ready is 1.
REQ-021 On an edge in DONE with out_ready=1, the FSM SHALL go to IDLE.
REQ-022 A new transfer is possible in the following cycle, so back-to-back throughput is 1 product per 6 cycles.
REQ-023 Latency SHALL be 4 cycles: after a transfer at edge N, out_valid is 1 after edge N+4.
REQ-024 Changes on a and b after the transfer SHALL NOT affect the result in progress.
REQ-025 in_valid in MUL or DONE SHALL be ignored; no request is queued.
REQ-026 out_ready asserted outside DONE SHALL have no effect.
REQ-027 out_valid SHALL be 0 in IDLE and MUL.
REQ-028 p SHALL hold its last value outside DONE, and 0 after reset.

Reset
REQ-029 When rst=1 at an edge, the block SHALL set:
- state to IDLE;
- step counter, accumulator, latched operands and p to 0;
- out_valid and busy to 0, in_ready to 1 on the following cycle.
REQ-030 Reset in MUL or DONE SHALL abort the operation silently, with no out_valid pulse.
REQ-031 Reset SHALL take priority over any simultaneous in_valid or out_ready.

Structure
REQ-032 A shared package mul8_pkg SHALL hold:
- the FSM state encoding (IDLE, MUL, DONE);
- step constants (NSTEPS=4);
- the per-step shift amounts (0, 4, 4, 8).
REQ-033 The block SHALL instantiate exactly one existing 4x4 combinational array multiplier, arr_mul, as its only sub-module.
REQ-034 Nibble-select multiplexers SHALL feed that sub-module, indexed by the step counter.
REQ-035 All other logic (FSM, counter, accumulator, handshake) SHALL be local to mul8_seq_ctrl.

Verification
REQ-036 a=0x12, b=0x34, transfer at edge N, out_ready=1 -> out_valid=1 after edge N+4, p=0x03A8, back to IDLE after edge N+5.
REQ-037 a=0xFF, b=0xFF -> p=0xFE01; a=0x00, b=0xA7 -> p=0x0000; a=0xA5, b=0x5A -> p=0x3A02.
REQ-038 Backpressure: out_ready=0 for 3 cycles in DONE while a and b toggle and in_valid=1 -> p stable, in_ready=0, no second transfer; then out_ready=1 -> IDLE.
REQ-039 Back-to-back: in_valid held 1 with 0x03*0x05 then 0x10*0x10 -> p=0x000F then p=0x0100, transfers 6 cycles apart.
REQ-040 rst=1 in MUL at step 2 -> no out_valid; in_ready=1 next cycle; next op 0x07*0x09 -> p=0x003F.
REQ-041 Random check: 1000 random operand pairs with random out_ready stalls -> each p matches a*b.
